// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: operand-forward select encodings and
// the E-stage control bubble used when the ID/EX register is flushed.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } e_ctrl_t;

  localparam e_ctrl_t E_CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Priority comparator choosing the forward source for one execute-stage operand.
// The M-stage result is newer than W, so it wins; register 0 is never forwarded.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_e,
  input  logic [REG_W-1:0] wr_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] wr_w,
  input  logic             reg_write_w,
  output logic [1:0]       fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (wr_m != '0) && (wr_m == src_e)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (wr_w != '0) && (wr_w == src_e)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: shadows destination registers through E/M/W,
// produces operand forward selects, load-use and multiply stalls, and flushes.
module hazard_forward_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int MULT_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] WriteRegD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MultStartD,
  input  logic             PCSrcD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MultBusy
);

  // A zero-latency build still needs a one-bit counter that simply stays at 0.
  localparam int CNT_W = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);

  logic [REG_W-1:0] rs_e_q, rs_e_d;
  logic [REG_W-1:0] rt_e_q, rt_e_d;
  logic [REG_W-1:0] wr_e_q, wr_e_d;
  e_ctrl_t          e_ctrl_q, e_ctrl_d;
  logic [REG_W-1:0] wr_m_q, wr_m_d;
  logic             reg_write_m_q, reg_write_m_d;
  logic [REG_W-1:0] wr_w_q, wr_w_d;
  logic             reg_write_w_q, reg_write_w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       lwstall;
  logic       mult_busy;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  always_comb begin
    lwstall   = e_ctrl_q.reg_write && e_ctrl_q.mem_to_reg && (wr_e_q != '0) &&
                ((wr_e_q == RsD) || (wr_e_q == RtD));
    mult_busy = (cnt_q != '0);
    stall     = lwstall || mult_busy;

    rs_e_d   = RsD;
    rt_e_d   = RtD;
    wr_e_d   = WriteRegD;
    e_ctrl_d = '{reg_write: RegWriteD, mem_to_reg: MemtoRegD};
    if (stall) begin
      rs_e_d   = '0;
      rt_e_d   = '0;
      wr_e_d   = '0;
      e_ctrl_d = E_CTRL_BUBBLE;
    end

    wr_m_d        = wr_e_q;
    reg_write_m_d = e_ctrl_q.reg_write;
    wr_w_d        = wr_m_q;
    reg_write_w_d = reg_write_m_q;

    // A multiply held in D during a stall is re-presented later, so it must not reload.
    cnt_d = cnt_q;
    if (MultStartD && !stall) begin
      cnt_d = MULT_LOAD;
    end else if (mult_busy) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_e_q        <= '0;
      rt_e_q        <= '0;
      wr_e_q        <= '0;
      e_ctrl_q      <= E_CTRL_BUBBLE;
      wr_m_q        <= '0;
      reg_write_m_q <= 1'b0;
      wr_w_q        <= '0;
      reg_write_w_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      rs_e_q        <= rs_e_d;
      rt_e_q        <= rt_e_d;
      wr_e_q        <= wr_e_d;
      e_ctrl_q      <= e_ctrl_d;
      wr_m_q        <= wr_m_d;
      reg_write_m_q <= reg_write_m_d;
      wr_w_q        <= wr_w_d;
      reg_write_w_q <= reg_write_w_d;
      cnt_q         <= cnt_d;
    end
  end

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src_e       (rs_e_q),
    .wr_m        (wr_m_q),
    .reg_write_m (reg_write_m_q),
    .wr_w        (wr_w_q),
    .reg_write_w (reg_write_w_q),
    .fwd         (fwd_a)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src_e       (rt_e_q),
    .wr_m        (wr_m_q),
    .reg_write_m (reg_write_m_q),
    .wr_w        (wr_w_q),
    .reg_write_w (reg_write_w_q),
    .fwd         (fwd_b)
  );

  // Outputs are held quiet while reset is asserted, even mid-multiply.
  assign ForwardAE = rst_n ? fwd_a : FWD_RF;
  assign ForwardBE = rst_n ? fwd_b : FWD_RF;
  assign StallF    = rst_n && stall;
  assign StallD    = rst_n && stall;
  assign FlushE    = rst_n && stall;
  assign FlushD    = rst_n && PCSrcD && !stall;
  assign MultBusy  = rst_n && mult_busy;

endmodule
